booth_divider_module: RTL and testbench
=======================================

Name: booth_divider_module

Overview:
- Signed two's-complement sequential divider; the inverse-direction companion to the team's Booth multiplier.
- Uses the same start_sig/done_sig request/acknowledge handshake, so one sequencer can drive either block.
- Restoring division on operand magnitudes, one quotient bit per clock, with sign correction at the end.
- Truncates toward zero; remainder takes the sign of the dividend.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (two's complement)

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start_sig  input  1  request; held high by master until done_sig seen
A  input  WIDTH  signed dividend, valid while start_sig high
B  input  WIDTH  signed divisor, valid while start_sig high
done_sig  output  1  one-cycle completion pulse
quotient  output  WIDTH  signed quotient, valid from done_sig, held until next done
remainder  output  WIDTH  signed remainder, valid from done_sig, held until next done
div_zero  output  1  B was 0 for the completed operation; held with quotient
overflow  output  1  A = most-negative and B = -1; held with quotient
SQ_r  output  WIDTH+1  debug: working partial remainder register
SQ_q  output  WIDTH  debug: working quotient shift register

Behaviour:
- Reset: clk and rst_n as already decided (reset rst_n, asynchronous, active-low; clock clk). Reset clears all outputs and internal registers to 0 and forces IDLE.
- Reset mid-operation abandons the operation; no done_sig is produced.
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - On an edge with start_sig=1 (edge E0), register |A|, |B|, sign(A), sign(A)^sign(B); clear SQ_r and the bit counter; SQ_q <= |A|.
  - |most-negative| is represented as an unsigned WIDTH-bit value (128 for WIDTH=8).
  - If B==0, go to DONE with the div-by-zero result staged. Otherwise go to ITER.
- ITER, one quotient bit per edge (E1..E_WIDTH):
  - Shift {SQ_r,SQ_q} left 1. Trial = SQ_r_shifted - {0,|B|}.
  - If trial >= 0: SQ_r <= trial, new LSB of SQ_q = 1. Else: keep shifted SQ_r, new LSB = 0.
  - Counter increments each edge; after WIDTH iterations go to FIX.
- FIX (edge E_WIDTH+1):
  - quotient <= negate(SQ_q) if signs differ, else SQ_q.
  - remainder <= negate(SQ_r[WIDTH-1:0]) if A was negative, else SQ_r.
  - overflow <= 1 if A = most-negative and B = -1; quotient then wraps to most-negative (8'h80), remainder 0. Otherwise overflow <= 0.
  - div_zero <= 0. done_sig <= 1. Go to DONE.
- Div-by-zero path: at E1 set quotient = all ones, remainder = A, div_zero=1, overflow=0, done_sig=1. Go to DONE.
- DONE: done_sig <= 0 on the next edge; go to IDLE.
- Timing:
  - done_sig is high exactly one cycle.
  - Latency from the start-sampling edge to the done-asserting edge is WIDTH+1 edges (1 edge for divide-by-zero).
  - Total occupancy is WIDTH+2 edges.
- Operands are sampled only at E0. Later changes to A, B or start_sig are ignored until the block returns to IDLE.
- Master drops start_sig on the edge where it sees done_sig, so the block sees start_sig=0 in IDLE. If start_sig is still high in IDLE, a new operation starts immediately with the current A/B (back-to-back allowed).
- quotient, remainder, div_zero and overflow change only at the done-asserting edge.

Test Plan:
- A=7, B=2 -> done after 9 edges; quotient=3, remainder=1, flags 0.
- A=-7 (8'hF9), B=2 -> quotient=8'hFD (-3), remainder=8'hFF (-1); A=7, B=-2 -> quotient=-3, remainder=1; A=-7, B=-2 -> quotient=3, remainder=-1.
- A=127, B=8'h81 (-127) -> quotient=8'hFF, remainder=0. A=8'h81, B=8'h81 -> quotient=1, remainder=0. A=-128, B=3 -> quotient=-42 (8'hD6), remainder=-2 (8'hFE).
- A=8'h80, B=8'hFF -> overflow=1, quotient=8'h80, remainder=0, done after 9 edges. A=5, B=0 -> div_zero=1, quotient=8'hFF, remainder=5, done 1 edge after start sampled.
- Sequencer protocol: four back-to-back requests, start dropped on done.
  - Each done_sig is a single-cycle pulse.
  - Results hold between dones.
  - Changing A/B mid-operation does not alter the result.
- Assert rst_n low during ITER:
  - All outputs go to 0 immediately, no done_sig.
  - After release, a new request 100/7 returns quotient=14, remainder=2.

Source files
------------

// File: rtl/booth_divider_module.sv
// -----------------------------------------------------------------------------
// booth_divider_module
//   Signed two's-complement sequential divider. It restores on operand
//   magnitudes and produces one quotient bit per clock. Signs are fixed up at
//   the end. The quotient truncates toward zero, and the remainder takes the
//   sign of the dividend.
//
// Handshake (start_sig / done_sig):
//   The master raises start_sig with A/B valid and holds it until it sees
//   done_sig. Operands are sampled only on the first edge where the block is
//   IDLE and start_sig is high. done_sig is a one-cycle pulse. The master drops
//   start_sig on the edge where it sees done_sig. If start_sig is still high
//   when the block is back in IDLE, a new operation starts with the current A/B.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start_sig  request, held until done_sig
//   A, B       signed dividend / divisor (WIDTH bits)
//   done_sig   one-cycle completion pulse
//   quotient   signed quotient, held until the next completion
//   remainder  signed remainder, held until the next completion
//   div_zero   completed operation had B == 0
//   overflow   completed operation was most-negative / -1
//   SQ_r       debug: working partial remainder (WIDTH+1 bits)
//   SQ_q       debug: working quotient shift register
// -----------------------------------------------------------------------------
module booth_divider_module #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_sig,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             done_sig,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow,
  output logic [WIDTH:0]   SQ_r,
  output logic [WIDTH-1:0] SQ_q
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   sq_r_q, sq_r_d;
  logic [WIDTH-1:0] sq_q_q, sq_q_d;
  logic [WIDTH-1:0] abs_b_q, abs_b_d;
  logic             neg_a_q, neg_a_d;   // dividend was negative
  logic             neg_qt_q, neg_qt_d; // operand signs differ
  logic             ovf_q, ovf_d;       // most-negative / -1 pending
  logic             dz_q, dz_d;         // divide-by-zero result pending
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] abs_a;

  always_comb begin
    state_d    = state_q;
    sq_r_d     = sq_r_q;
    sq_q_d     = sq_q_q;
    abs_b_d    = abs_b_q;
    neg_a_d    = neg_a_q;
    neg_qt_d   = neg_qt_q;
    ovf_d      = ovf_q;
    dz_d       = dz_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    done_d     = done_q;
    div_zero_d = div_zero_q;
    overflow_d = overflow_q;
    abs_a      = A[WIDTH-1] ? ('0 - A) : A;
    // One extra bit on the trial subtraction so its MSB is the borrow.
    shifted    = {sq_r_q[WIDTH-1:0], sq_q_q[WIDTH-1]};
    trial      = {1'b0, shifted} - {2'b00, abs_b_q};

    case (state_q)
      S_IDLE: begin
        if (start_sig) begin
          // |most-negative| fits as an unsigned WIDTH-bit value.
          sq_q_d   = abs_a;
          sq_r_d   = '0;
          cnt_d    = '0;
          abs_b_d  = B[WIDTH-1] ? ('0 - B) : B;
          neg_a_d  = A[WIDTH-1];
          neg_qt_d = A[WIDTH-1] ^ B[WIDTH-1];
          ovf_d    = (A == MOST_NEG) && (B == '1);
          dz_d     = (B == '0);
          state_d  = (B == '0) ? S_DONE : S_ITER;
        end
      end
      S_ITER: begin
        sq_r_d = trial[WIDTH+1] ? shifted : trial[WIDTH:0];
        sq_q_d = {sq_q_q[WIDTH-2:0], ~trial[WIDTH+1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (ovf_q) begin
          quot_d     = MOST_NEG;
          rem_d      = '0;
          overflow_d = 1'b1;
        end else begin
          quot_d     = neg_qt_q ? ('0 - sq_q_q) : sq_q_q;
          rem_d      = neg_a_q ? ('0 - sq_r_q[WIDTH-1:0]) : sq_r_q[WIDTH-1:0];
          overflow_d = 1'b0;
        end
        div_zero_d = 1'b0;
        done_d     = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (dz_q) begin
          // Divide-by-zero enters DONE straight from IDLE. It publishes its
          // result on this first DONE edge, then leaves on the next one.
          quot_d     = '1;
          rem_d      = neg_a_q ? ('0 - sq_q_q) : sq_q_q;
          div_zero_d = 1'b1;
          overflow_d = 1'b0;
          done_d     = 1'b1;
          dz_d       = 1'b0;
        end else begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_r_q     <= '0;
      sq_q_q     <= '0;
      abs_b_q    <= '0;
      neg_a_q    <= 1'b0;
      neg_qt_q   <= 1'b0;
      ovf_q      <= 1'b0;
      dz_q       <= 1'b0;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sq_r_q     <= sq_r_d;
      sq_q_q     <= sq_q_d;
      abs_b_q    <= abs_b_d;
      neg_a_q    <= neg_a_d;
      neg_qt_q   <= neg_qt_d;
      ovf_q      <= ovf_d;
      dz_q       <= dz_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign done_sig  = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;
  assign SQ_r      = sq_r_q;
  assign SQ_q      = sq_q_q;

endmodule

// File: tb/tb_booth_divider_module.sv
// -----------------------------------------------------------------------------
// tb_booth_divider_module
//   Directed and randomized checks of booth_divider_module against a plain
//   integer-arithmetic reference (SV '/' and '%' truncate toward zero).
// -----------------------------------------------------------------------------
module tb_booth_divider_module;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start_sig;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         done_sig;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  logic         overflow;
  logic [W:0]   SQ_r;
  logic [W-1:0] SQ_q;

  int passed;
  int total;

  // Results the block is expected to be holding between completions.
  logic [W-1:0] hold_q;
  logic [W-1:0] hold_r;
  logic         hold_dz;
  logic         hold_ov;

  booth_divider_module #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_sig (start_sig),
    .A         (A),
    .B         (B),
    .done_sig  (done_sig),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow),
    .SQ_r      (SQ_r),
    .SQ_q      (SQ_q)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: signed integer division with the block's special cases.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output logic ov, output int lat);
    int ia;
    int ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    lat = W + 1;
    if (ib == 0) begin
      q = '1;
      r = a;
      dz = 1'b1;
      lat = 1;
    end else if (ia == -(1 << (W - 1)) && ib == -1) begin
      q = a;
      r = '0;
      ov = 1'b1;
    end else begin
      q = W'(ia / ib);
      r = W'(ia % ib);
    end
  endtask

  // Driver: one request, start dropped on done. With scramble set, A/B are
  // randomized right after the sampling edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic edz;
    logic eov;
    int lat;
    int n;
    model(a, b, eq, er, edz, eov, lat);
    @(negedge clk);
    A = a;
    B = b;
    start_sig = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (scramble && n == 1) begin
        A = W'($urandom);
        B = W'($urandom);
      end
      if (!done_sig) begin
        check("hold_quotient", quotient, hold_q);
        check("hold_remainder", remainder, hold_r);
      end
    end while (!done_sig && n < 40);
    start_sig = 1'b0;
    check("done_seen", done_sig, 1);
    check("latency", n - 1, lat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", div_zero, edz);
    check("overflow", overflow, eov);
    hold_q = eq;
    hold_r = er;
    hold_dz = edz;
    hold_ov = eov;
    @(posedge clk);
    #1;
    check("done_pulse", done_sig, 0);
    check("post_hold_q", quotient, hold_q);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    passed = 0;
    total = 0;
    hold_q = '0;
    hold_r = '0;
    hold_dz = 1'b0;
    hold_ov = 1'b0;
    start_sig = 1'b0;
    A = '0;
    B = '0;

    // reset
    rst_n = 1'b0;
    #1;
    check("rst_done", done_sig, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_flags", {div_zero, overflow}, 0);
    check("rst_sqr", SQ_r, 0);
    check("rst_sqq", SQ_q, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    do_op(8'd7,   8'd2,   1'b0);
    do_op(8'hF9,  8'd2,   1'b0);
    do_op(8'd7,   8'hFE,  1'b0);
    do_op(8'hF9,  8'hFE,  1'b0);
    do_op(8'd127, 8'h81,  1'b0);
    do_op(8'h81,  8'h81,  1'b0);
    do_op(8'h80,  8'd3,   1'b0);
    do_op(8'h80,  8'hFF,  1'b0);
    do_op(8'd5,   8'd0,   1'b0);
    do_op(8'h80,  8'd0,   1'b0);
    do_op(8'h80,  8'h80,  1'b0);
    do_op(8'd127, 8'd1,   1'b0);

    // four back-to-back requests with operands changed mid-operation
    do_op(8'd100, 8'd9,   1'b1);
    do_op(8'hC3,  8'd5,   1'b1);
    do_op(8'd0,   8'hFB,  1'b1);
    do_op(8'd77,  8'd0,   1'b1);

    // randomized stimulus with biased corners
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 8'h80;
      if ($urandom_range(0, 7) == 0) rb = 8'hFF;
      if ($urandom_range(0, 9) == 0) rb = 8'h00;
      do_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    // leave a non-zero result held, then reset during ITER
    do_op(8'd50, 8'd3, 1'b0);
    @(negedge clk);
    A = 8'd90;
    B = 8'd4;
    start_sig = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_done", done_sig, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_flags", {div_zero, overflow}, 0);
    check("midrst_sqr", SQ_r, 0);
    check("midrst_sqq", SQ_q, 0);
    start_sig = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("midrst_no_done", done_sig, 0);
      if (i == 2) rst_n = 1'b1;
    end
    hold_q = '0;
    hold_r = '0;
    hold_dz = 1'b0;
    hold_ov = 1'b0;
    do_op(8'd100, 8'd7, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
